lap_timer: RTL and testbench
============================

Name: lap_timer

Overview:
- Parametrised successor of the single-button stopwatch.
- Adds separate start/stop and lap/clear buttons with internal edge detection, a pause state, configurable tick prescaler and count width, and selectable wrap/saturate at max.
- Lap times are captured into a small FIFO that is drained over a valid/ready port.
- Sits between the synchronised button inputs and the display or readout logic.

Parameters:
- CLK_DIV, 100: clk cycles per time tick; must be >= 2.
- CNT_W, 8: width of the time counter and lap entries.
- LAP_DEPTH, 4: lap FIFO entries; power of two, >= 2.
- WRAP, 1: 1 = time wraps to 0 after 2^CNT_W-1; 0 = time saturates at max and sets overflow.

Ports:
- clk  in  1  system clock.
- nRst_i  in  1  asynchronous active-low reset.
- start_i  in  1  start/stop button, level, already synchronised.
- lap_i  in  1  lap/clear button, level, already synchronised.
- mode_o  out  2  current state (sw_state_t).
- time_o  out  CNT_W  current elapsed ticks.
- overflow_o  out  1  sticky; set when saturated at max (WRAP=0 only).
- lap_valid_o  out  1  lap FIFO head valid.
- lap_data_o  out  CNT_W  lap FIFO head value.
- lap_ready_i  in  1  consumer accepts head.
- lap_drop_o  out  1  one-cycle pulse when a lap is lost because the FIFO is full.

Behaviour:
- Clocking and reset: single clock domain, posedge clk. Reset is asynchronous and active-low.
- Reset values: mode_o=IDLE, time_o=0, overflow_o=0, lap_valid_o=0, lap_data_o=0, lap_drop_o=0. Prescaler, FIFO pointers and edge registers are all 0.
- Reset asserted mid-operation clears everything immediately.
- Edge detect: start_p = start_i & ~start_q; lap_p = lap_i & ~lap_q. The _q registers are updated every cycle. A held button yields exactly one pulse.
- Simultaneous pulses: if start_p and lap_p occur in the same cycle, start wins and lap_p is ignored.
- States (sw_state_t): IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2; 2'd3 is illegal and goes to IDLE.
- Transitions:
  - IDLE + start_p -> RUNNING.
  - RUNNING + start_p -> PAUSED.
  - PAUSED + start_p -> RUNNING.
  - PAUSED + lap_p -> IDLE. This clears time_o, the prescaler and overflow_o, and flushes the FIFO, all in the same edge.
  - RUNNING + lap_p -> stays RUNNING and pushes a lap.
  - IDLE + lap_p -> ignored.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUNNING and holds in PAUSED.
  - tick = (RUNNING && presc==CLK_DIV-1); presc then returns to 0.
  - Entering RUNNING from IDLE: first tick occurs CLK_DIV cycles after the transition edge.
  - Resuming from PAUSED keeps the partial prescaler count.
- Time counter:
  - On tick, time_o+1.
  - At max with WRAP=1: next value 0, overflow_o stays 0.
  - At max with WRAP=0: holds max and sets overflow_o on that tick.
- Lap push:
  - Value pushed is the time_o register value in the push cycle (pre-increment if tick coincides).
  - Push is accepted if FIFO not full, or if full and a pop occurs in the same cycle.
  - Otherwise the lap is dropped and lap_drop_o=1 for one cycle.
- Lap pop: occurs when lap_valid_o && lap_ready_i; head advances next cycle.
- Flush: a flush has priority over any push or pop in the same cycle.
- FIFO timing: lap_data_o is stable while lap_valid_o=1 and lap_ready_i=0. A push into an empty FIFO raises lap_valid_o on the next cycle (1-cycle latency).

Optional Feature:
- Macro: LAP_TIMER_BCD_EN.
- Defined: adds output time_bcd_o [4*ND-1:0], where ND = ceil(log10(2^CNT_W)). It is the BCD of time_o, maintained incrementally by a cascaded digit counter that increments on tick and clears together with time_o, so it is in the same cycle as time_o.
  - WRAP=1: rolls to 0 together with time_o.
  - WRAP=0: saturates together with time_o.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package stopwatch_pkg: sw_state_t enum (IDLE/RUNNING/PAUSED) and the function clog2-based pointer-width helper.
- Sub-module lap_fifo, parametrised on CNT_W and LAP_DEPTH. Ports: clk, nRst_i, push, push_data, flush, pop_ready, valid, data, drop. It owns the full/empty logic and the drop pulse.
- Prescaler, edge detect and FSM stay in lap_timer.

Test Plan:
- Reset/idle: hold nRst_i=0, then release; pulse lap_i -> mode_o=0, time_o=0, lap_valid_o=0 throughout.
- Count and pause (CLK_DIV=4, CNT_W=4):
  - start pulse, wait 12 cycles -> time_o=3.
  - start pulse -> mode_o=2, time_o holds 3 for 20 cycles.
  - start pulse -> resumes; next tick follows from the retained prescaler count.
- Wrap vs saturate (CNT_W=3):
  - WRAP=1: run 9 ticks -> time_o=1, overflow_o=0.
  - WRAP=0: run 9 ticks -> time_o=7, overflow_o=1.
- Laps and backpressure (LAP_DEPTH=4, lap_ready_i=0):
  - 5 lap pulses while RUNNING -> 4 entries stored; lap_drop_o pulses once on the 5th.
  - Raise lap_ready_i -> values drain in capture order.
- Simultaneous events:
  - start_i and lap_i rise together while RUNNING -> PAUSED, no lap pushed.
  - Lap pulse on a tick cycle with time_o=5 -> pushed value 5.
- Clear: from PAUSED with 2 laps queued and overflow_o=1, lap pulse -> mode_o=0, time_o=0, overflow_o=0, lap_valid_o=0 the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and width helpers for the lap timer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // Decimal digits needed for 2^w-1, i.e. ceil(log10(2^w)).
    function automatic int unsigned bcd_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Lap capture FIFO: valid/ready head, push-while-full-with-pop, flush priority, drop pulse.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             nRst_i,
    input  logic             push,
    input  logic [CNT_W-1:0] push_data,
    input  logic             flush,
    input  logic             pop_ready,
    output logic             valid,
    output logic [CNT_W-1:0] data,
    output logic             drop
);
    localparam int unsigned PW = ptr_w(LAP_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, drop_q, drop_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] mem_q [LAP_DEPTH];
    logic             full, pop, push_ok;

    // Head register tracks mem[rd_d], bypassing the entry written this edge.
    always_comb begin
        full    = (cnt_q == CW'(LAP_DEPTH));
        pop     = valid_q && pop_ready;
        push_ok = push && (!full || pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        data_d  = data_q;
        if (flush) begin
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
            data_d = '0;
        end else begin
            if (pop)     rd_d = rd_q + PW'(1);
            if (push_ok) wr_d = wr_q + PW'(1);
            cnt_d  = cnt_q + CW'(push_ok) - CW'(pop);
            drop_d = push && !push_ok;
            if (cnt_d == '0)                    data_d = '0;
            else if (push_ok && wr_q == rd_d)   data_d = push_data;
            else                                data_d = mem_q[rd_d];
        end
        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < int'(LAP_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            if (!flush && push_ok) mem_q[wr_q] <= push_data;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign drop  = drop_q;

endmodule

// File: rtl/lap_timer.sv
// Two-button lap timer with prescaler, pause, wrap/saturate and lap FIFO.
// Optional BCD readout of time_o when LAP_TIMER_BCD_EN is defined.
module lap_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned WRAP      = 1
) (
    input  logic             clk,
    input  logic             nRst_i,
    input  logic             start_i,
    input  logic             lap_i,
    output logic [1:0]       mode_o,
    output logic [CNT_W-1:0] time_o,
    output logic             overflow_o,
    output logic             lap_valid_o,
    output logic [CNT_W-1:0] lap_data_o,
    input  logic             lap_ready_i,
    output logic             lap_drop_o
`ifdef LAP_TIMER_BCD_EN
    ,output logic [4*bcd_digits(CNT_W)-1:0] time_bcd_o
`endif
);
    localparam int unsigned      PRESC_W  = ptr_w(CLK_DIV);
    localparam logic [CNT_W-1:0] TIME_MAX = '1;

    sw_state_t          state_q, state_d;
    logic               start_q, lap_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   time_q, time_d;
    logic               ovf_q, ovf_d;
    logic               start_p, lap_p, tick, push, flush;

    always_comb begin
        start_p = start_i & ~start_q;
        lap_p   = lap_i & ~lap_q;
        tick    = (state_q == RUNNING) && (presc_q == PRESC_W'(CLK_DIV - 1));
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (state_q == RUNNING) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick) begin
                if (time_q != TIME_MAX) time_d = time_q + CNT_W'(1);
                else if (WRAP != 0)     time_d = '0;
                else                    ovf_d  = 1'b1;
            end
        end
        // start_p outranks lap_p in every state
        case (state_q)
            IDLE:    if (start_p) state_d = RUNNING;
            RUNNING: if (start_p) state_d = PAUSED;  else if (lap_p) push  = 1'b1;
            PAUSED:  if (start_p) state_d = RUNNING; else if (lap_p) flush = 1'b1;
            default: flush = 1'b1;
        endcase
        if (flush) begin
            state_d = IDLE;
            presc_d = '0;
            time_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            lap_q   <= 1'b0;
            presc_q <= '0;
            time_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            lap_q   <= lap_i;
            presc_q <= presc_d;
            time_q  <= time_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mode_o     = state_q;
    assign time_o     = time_q;
    assign overflow_o = ovf_q;

    lap_fifo #(
        .CNT_W     (CNT_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nRst_i    (nRst_i),
        .push      (push),
        .push_data (time_q),
        .flush     (flush),
        .pop_ready (lap_ready_i),
        .valid     (lap_valid_o),
        .data      (lap_data_o),
        .drop      (lap_drop_o)
    );

`ifdef LAP_TIMER_BCD_EN
    localparam int unsigned ND = bcd_digits(CNT_W);

    logic [4*ND-1:0] bcd_q, bcd_d;
    logic            carry;

    // Ripple-carry decimal counter shadowing time_q.
    always_comb begin
        bcd_d = bcd_q;
        carry = 1'b1;
        if (flush) begin
            bcd_d = '0;
        end else if (tick) begin
            if (time_q == TIME_MAX) begin
                if (WRAP != 0) bcd_d = '0;
            end else begin
                for (int i = 0; i < int'(ND); i++) begin
                    if (carry) begin
                        if (bcd_q[4*i +: 4] == 4'd9) begin
                            bcd_d[4*i +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) bcd_q <= '0;
        else         bcd_q <= bcd_d;
    end

    assign time_bcd_o = bcd_q;
`endif

endmodule

// File: tb/tb_lap_timer.sv
// Lap timer bench: wrap and saturate instances on shared stimulus, checked against a queue-based model.
module tb_lap_timer;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 3;
    localparam int DEPTH   = 4;
    localparam int MAXV    = 7;

    logic clk = 1'b0, nRst_i = 1'b0, start_i = 1'b0, lap_i = 1'b0, lap_ready_i = 1'b0;

    logic [1:0]       w_mode, s_mode;
    logic [CNT_W-1:0] w_time, s_time, w_data, s_data;
    logic             w_ovf, s_ovf, w_valid, s_valid, w_drop, s_drop;

    lap_timer #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .LAP_DEPTH(DEPTH), .WRAP(1)) u_wrap (
        .clk(clk), .nRst_i(nRst_i), .start_i(start_i), .lap_i(lap_i),
        .mode_o(w_mode), .time_o(w_time), .overflow_o(w_ovf),
        .lap_valid_o(w_valid), .lap_data_o(w_data), .lap_ready_i(lap_ready_i),
        .lap_drop_o(w_drop)
    );

    lap_timer #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W), .LAP_DEPTH(DEPTH), .WRAP(0)) u_sat (
        .clk(clk), .nRst_i(nRst_i), .start_i(start_i), .lap_i(lap_i),
        .mode_o(s_mode), .time_o(s_time), .overflow_o(s_ovf),
        .lap_valid_o(s_valid), .lap_data_o(s_data), .lap_ready_i(lap_ready_i),
        .lap_drop_o(s_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int drop_seen = 0;

    // Reference state per instance (0 = wrap, 1 = saturate)
    int m_mode[2], m_presc[2], m_time[2], m_ovf[2], m_drop[2];
    int q_w[$], q_s[$];
    bit m_start_prev, m_lap_prev;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_mode[u] = 0; m_presc[u] = 0; m_time[u] = 0; m_ovf[u] = 0; m_drop[u] = 0;
        end
        q_w.delete();
        q_s.delete();
        m_start_prev = 1'b0;
        m_lap_prev   = 1'b0;
    endtask

    task automatic model_unit(input int u, input bit sp, input bit lp, input bit wrap);
        int q[$];
        int md, nm, nt, np, no;
        bit push, flush, pop;
        if (u == 0) q = q_w; else q = q_s;
        md = m_mode[u]; nm = md; nt = m_time[u]; np = m_presc[u]; no = m_ovf[u];
        push = 1'b0; flush = 1'b0;
        pop = (q.size() > 0) && lap_ready_i;
        if (md == 1) begin
            if (m_presc[u] == CLK_DIV - 1) begin
                np = 0;
                if (m_time[u] == MAXV) begin
                    if (wrap) nt = 0; else no = 1;
                end else nt = m_time[u] + 1;
            end else np = m_presc[u] + 1;
        end
        if (sp) nm = (md == 1) ? 2 : 1;
        else if (lp && md == 1) push = 1'b1;
        else if (lp && md == 2) flush = 1'b1;
        m_drop[u] = 0;
        if (flush) begin
            nm = 0; nt = 0; np = 0; no = 0;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(m_time[u]);
                else m_drop[u] = 1;
            end
        end
        m_mode[u] = nm; m_time[u] = nt; m_presc[u] = np; m_ovf[u] = no;
        if (u == 0) q_w = q; else q_s = q;
    endtask

    task automatic check_unit(input int u);
        int q[$];
        int mode, tm, ov, vl, dt, dr;
        string nm;
        if (u == 0) begin
            q = q_w; nm = "wrap";
            mode = int'(w_mode); tm = int'(w_time); ov = int'(w_ovf);
            vl = int'(w_valid); dt = int'(w_data); dr = int'(w_drop);
        end else begin
            q = q_s; nm = "sat";
            mode = int'(s_mode); tm = int'(s_time); ov = int'(s_ovf);
            vl = int'(s_valid); dt = int'(s_data); dr = int'(s_drop);
        end
        chk({nm, "_mode"},  mode, m_mode[u]);
        chk({nm, "_time"},  tm,   m_time[u]);
        chk({nm, "_ovf"},   ov,   m_ovf[u]);
        chk({nm, "_drop"},  dr,   m_drop[u]);
        chk({nm, "_valid"}, vl,   (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) chk({nm, "_data"}, dt, q[0]);
    endtask

    // Advance model and DUTs one clock, then compare 1 time unit after the edge.
    task automatic step();
        bit sp, lp;
        sp = start_i && !m_start_prev;
        lp = lap_i && !m_lap_prev;
        model_unit(0, sp, lp, 1'b1);
        model_unit(1, sp, lp, 1'b0);
        m_start_prev = start_i;
        m_lap_prev   = lap_i;
        @(posedge clk);
        #1;
        check_unit(0);
        check_unit(1);
        if (w_drop) drop_seen++;
    endtask

    task automatic lap_pulse();
        lap_i = 1'b1; step();
        lap_i = 1'b0; step();
    endtask

    task automatic start_pulse();
        start_i = 1'b1; step();
        start_i = 1'b0; step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode",  int'(w_mode),  0);
        chk("rst_time",  int'(w_time),  0);
        chk("rst_ovf",   int'(s_ovf),   0);
        chk("rst_valid", int'(w_valid), 0);
        chk("rst_data",  int'(w_data),  0);
        chk("rst_drop",  int'(w_drop),  0);
        nRst_i = 1'b1;

        // Lap in IDLE is ignored
        lap_pulse();
        chk("idle_mode",  int'(w_mode),  0);
        chk("idle_valid", int'(w_valid), 0);

        // Count, pause, resume with retained prescaler
        start_i = 1'b1; step();
        chk("run_mode", int'(w_mode), 1);
        repeat (12) step();
        chk("t12", int'(w_time), 3);
        start_i = 1'b0; step();
        start_i = 1'b1; step();
        chk("pause_mode", int'(w_mode), 2);
        repeat (20) begin
            step();
            chk("pause_hold", int'(w_time), 3);
        end
        start_i = 1'b0; step();
        start_i = 1'b1; step();
        chk("resume_mode", int'(w_mode), 1);
        start_i = 1'b0; step();
        chk("resume_t3", int'(w_time), 3);
        step();
        chk("resume_t4", int'(w_time), 4);

        // Pause then clear, then 9 ticks: wrap vs saturate
        start_pulse();
        lap_pulse();
        chk("clr_mode", int'(w_mode), 0);
        chk("clr_time", int'(s_time), 0);
        start_i = 1'b1; step();
        start_i = 1'b0;
        repeat (36) step();
        chk("wrap_time", int'(w_time), 1);
        chk("wrap_ovf",  int'(w_ovf),  0);
        chk("sat_time",  int'(s_time), 7);
        chk("sat_ovf",   int'(s_ovf),  1);

        // Backpressure: five laps into a four-deep FIFO
        lap_ready_i = 1'b0;
        drop_seen   = 0;
        repeat (5) lap_pulse();
        chk("drop_count", drop_seen, 1);
        chk("full_valid", int'(w_valid), 1);
        lap_ready_i = 1'b1;
        repeat (6) step();
        chk("drained", int'(w_valid), 0);
        lap_ready_i = 1'b0;

        // start and lap together: pause wins, nothing pushed
        start_i = 1'b1; lap_i = 1'b1; step();
        chk("simul_mode",  int'(w_mode),  2);
        chk("simul_valid", int'(w_valid), 0);
        start_i = 1'b0; lap_i = 1'b0; step();

        // Two laps queued, overflow set, then clear from PAUSED
        start_pulse();
        repeat (2) lap_pulse();
        start_pulse();
        chk("preclr_ovf",   int'(s_ovf),   1);
        chk("preclr_valid", int'(s_valid), 1);
        lap_i = 1'b1; step();
        chk("clr2_mode",  int'(s_mode),  0);
        chk("clr2_time",  int'(s_time),  0);
        chk("clr2_ovf",   int'(s_ovf),   0);
        chk("clr2_valid", int'(s_valid), 0);
        lap_i = 1'b0; step();

        // Lap sampled on the tick that moves time 5 -> 6
        start_i = 1'b1; step();
        start_i = 1'b0;
        repeat (23) step();
        lap_i = 1'b1; step();
        chk("tick_lap_data",  int'(w_data),  5);
        chk("tick_lap_valid", int'(w_valid), 1);
        chk("tick_lap_time",  int'(w_time),  6);
        lap_i = 1'b0; step();

        // Randomised run with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) start_i = ~start_i;
            if ($urandom_range(0, 5) == 0)  lap_i   = ~lap_i;
            lap_ready_i = ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #2 nRst_i = 1'b0;
                #1;
                model_reset();
                chk("midrst_mode",  int'(w_mode),  0);
                chk("midrst_time",  int'(s_time),  0);
                chk("midrst_valid", int'(w_valid), 0);
                chk("midrst_data",  int'(w_data),  0);
                nRst_i = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
